// File: rtl/fpga_ip_demo_cpu_oci_trace_monitor_pkg.sv
// Shared definitions for the CPU OCI trace monitor: controller state encoding,
// record width helper and timestamp width.
// Optional build macro: OCI_TRACE_TIMESTAMP_EN (adds a 32-bit cycle timestamp
// at the top of every record).
package fpga_ip_demo_oci_trace_pkg;

    localparam int TS_W = 32;

`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FLUSH   = 2'd1,
        ENDED   = 2'd2
    } state_t;

    // Width of one stored record: [timestamp,] count, frame buffer.
    function automatic int rec_w(input int slots, input int frame_w,
                                 input int cnt_w, input bit ts_en);
        return slots * frame_w + cnt_w + (ts_en ? TS_W : 0);
    endfunction

endpackage

// File: rtl/fpga_ip_demo_cpu_oci_trace_monitor_if.sv
// Record stream between the trace monitor (master) and its consumer (slave),
// a plain valid/ready handshake. Transfer happens on rec_valid & rec_ready.
interface fpga_ip_demo_cpu_oci_trace_monitor_if #(
    parameter int WIDTH = fpga_ip_demo_oci_trace_pkg::rec_w(15, 2, 4, fpga_ip_demo_oci_trace_pkg::TS_EN)
) ();

    logic [WIDTH-1:0] rec_data;
    logic             rec_valid;
    logic             rec_ready;

    modport master (output rec_data, output rec_valid, input rec_ready);
    modport slave  (input rec_data, input rec_valid, output rec_ready);

endinterface

// File: rtl/fpga_ip_demo_cpu_oci_trace_monitor_fifo.sv
// Generic first-word-fall-through FIFO with occupancy output.
// The head entry is visible on rd_data whenever rd_valid is high. A push into
// a full FIFO is accepted only when a pop happens in the same cycle; otherwise
// it is refused and the caller decides what to do with it.
module fpga_ip_demo_oci_trace_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (level != '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign do_pop   = pop && rd_valid;
    assign do_push  = push && (!full || do_pop);
    // Empty FIFO shows zero so the stream never exposes stale storage.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage write on accepted push.
    // NOTE: the storage array has no reset; the pointers and level define what
    // is valid, and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fpga_ip_demo_cpu_oci_trace_monitor.sv
// CPU OCI trace monitor: captures DCT snapshots (masked frame buffer plus
// frame count) into a FWFT FIFO, streams them out over valid/ready, counts
// records lost to a full FIFO and tracks the end-of-test sequence.
// Optional build macro: OCI_TRACE_TIMESTAMP_EN prepends a free-running 32-bit
// cycle count (value at the push cycle) to each record.
module fpga_ip_demo_cpu_oci_trace_monitor
    import fpga_ip_demo_oci_trace_pkg::*;
#(
    parameter  int FRAME_W = 2,
    parameter  int SLOTS   = 15,
    parameter  int DEPTH   = 8,
    parameter  int DROP_W  = 16,
    localparam int CNT_W   = $clog2(SLOTS + 1),
    localparam int BUF_W   = SLOTS * FRAME_W,
    localparam int REC_W   = rec_w(SLOTS, FRAME_W, CNT_W, TS_EN),
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUF_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              dct_valid,
    input  logic              test_ending,
    input  logic              test_has_ended,
    fpga_ip_demo_cpu_oci_trace_monitor_if.master rec,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [DROP_W-1:0] drop_count,
    output logic              done
);

    state_t           state;
    logic [CNT_W-1:0] cnt_clamped;
    logic [BUF_W-1:0] masked_buf;
    logic [REC_W-1:0] push_data;
    logic [REC_W-1:0] head_data;
    logic             head_valid;
    logic             capture_req;
    logic             pop;
    logic             full;
    logic             drop;

    // Clamp the stored count and zero every frame at or beyond it.
    // NOTE: each always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_clamped = dct_count;
        if (32'(dct_count) > SLOTS) begin
            cnt_clamped = CNT_W'(SLOTS);
        end
        masked_buf = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (i < int'(cnt_clamped)) begin
                masked_buf[i*FRAME_W +: FRAME_W] = dct_buffer[i*FRAME_W +: FRAME_W];
            end
        end
    end

    // Snapshots are only taken while capturing; empty snapshots are ignored.
    assign capture_req = (state == CAPTURE) && dct_valid && (dct_count != '0);
    assign pop         = head_valid && rec.rec_ready;
    assign drop        = capture_req && full && !pop;

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign push_data = {ts_q, cnt_clamped, masked_buf};
`else
    assign push_data = {cnt_clamped, masked_buf};
`endif

    fpga_ip_demo_oci_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_req),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (head_data),
        .rd_valid  (head_valid),
        .full      (full),
        .level     (fifo_level)
    );

    assign rec.rec_data  = head_data;
    assign rec.rec_valid = head_valid;

    // Saturating count of snapshots lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    // End-of-test controller; done is registered one cycle behind ENDED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CAPTURE;
            done  <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (test_ending || test_has_ended) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (test_has_ended && (fifo_level == '0)) begin
                        state <= ENDED;
                    end
                end
                ENDED:   state <= ENDED;
                default: state <= CAPTURE;
            endcase
            done <= (state == ENDED);
        end
    end

endmodule

// File: tb/tb_fpga_ip_demo_cpu_oci_trace_monitor.sv
// Self-checking bench for the CPU OCI trace monitor. A queue-based model of
// the record stream predicts occupancy, head record, drops and done.
module tb_fpga_ip_demo_cpu_oci_trace_monitor;
    import fpga_ip_demo_oci_trace_pkg::*;

    localparam int FRAME_W = 2;
    localparam int SLOTS   = 15;
    localparam int DEPTH   = 8;
    localparam int DROP_W  = 16;
    localparam int CNT_W   = $clog2(SLOTS + 1);
    localparam int BUF_W   = SLOTS * FRAME_W;
    localparam int REC_W   = rec_w(SLOTS, FRAME_W, CNT_W, TS_EN);
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    typedef logic [REC_W-1:0] rec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              dct_valid;
    logic              test_ending;
    logic              test_has_ended;
    logic [LVL_W-1:0]  fifo_level;
    logic [DROP_W-1:0] drop_count;
    logic              done;

    fpga_ip_demo_cpu_oci_trace_monitor_if #(.WIDTH(REC_W)) rif ();

    fpga_ip_demo_cpu_oci_trace_monitor #(
        .FRAME_W (FRAME_W),
        .SLOTS   (SLOTS),
        .DEPTH   (DEPTH),
        .DROP_W  (DROP_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rec            (rif),
        .fifo_level     (fifo_level),
        .drop_count     (drop_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    rec_t        q[$];
    int          m_drops;
    bit          m_capturing;
    bit          m_ended;
    bit          m_done;
    int unsigned m_cyc;

    // Expected record: count limited to SLOTS, frames beyond it zeroed.
    function automatic rec_t make_rec(input logic [BUF_W-1:0] b, input int cnt,
                                      input int unsigned ts);
        int              kept;
        longint unsigned keep_mask;
        rec_t            r;
        kept      = (cnt > SLOTS) ? SLOTS : cnt;
        keep_mask = (64'd1 << (kept * FRAME_W)) - 64'd1;
        r         = '0;
        r[BUF_W-1:0]      = BUF_W'(64'(b) & keep_mask);
        r[BUF_W +: CNT_W] = CNT_W'(kept);
`ifdef OCI_TRACE_TIMESTAMP_EN
        r[REC_W-1 -: TS_W] = ts;
`else
        if (ts == 32'hFFFF_FFFF) r = r;
`endif
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        m_drops     = 0;
        m_capturing = 1'b1;
        m_ended     = 1'b0;
        m_done      = 1'b0;
        m_cyc       = 0;
    endtask

    task automatic set_in(input bit dv, input int cnt, input logic [BUF_W-1:0] b,
                          input bit rdy);
        dct_valid     = dv;
        dct_count     = CNT_W'(cnt);
        dct_buffer    = b;
        rif.rec_ready = rdy;
    endtask

    // Advance one clock, updating the model from the inputs now applied.
    task automatic tick();
        int sz;
        bit pop_m;
        bit push_m;
        sz     = q.size();
        pop_m  = (sz != 0) && (rif.rec_ready === 1'b1);
        push_m = m_capturing && (dct_valid === 1'b1) && (dct_count != 0);
        m_done = m_ended;
        if (pop_m) void'(q.pop_front());
        if (push_m) begin
            if (sz < DEPTH || pop_m) q.push_back(make_rec(dct_buffer, int'(dct_count), m_cyc));
            else if (m_drops < 65535) m_drops++;
        end
        m_ended     = m_ended || (!m_capturing && test_has_ended && sz == 0);
        m_capturing = m_capturing && !(test_ending || test_has_ended);
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        set_in(1'b0, 0, '0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        set_in(1'b0, 0, '0, 1'b0);
        model_clear();
        #2;
        total++; if (rif.rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rif.rec_valid); end
        total++; if (rif.rec_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", rif.rec_data); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (drop_count !== '0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_first_capture();
        rec_t want;
        set_in(1'b1, 3, 30'h3FFF_FFFF, 1'b0);
        tick();
        set_in(1'b0, 0, '0, 1'b0);
        want = '0;
        want[BUF_W +: CNT_W] = CNT_W'(3);
        want[BUF_W-1:0]      = BUF_W'(30'h0000_003F);
        total++; if (rif.rec_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", rif.rec_valid); end
        total++; if (rif.rec_data[BUF_W+CNT_W-1:0] !== want[BUF_W+CNT_W-1:0]) begin bad++; $display("FAIL first_data: got %h want %h", rif.rec_data, want); end
        total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL first_model: got %h want %h", rif.rec_data, q[0]); end
        tick();
        total++; if (rif.rec_data !== want[BUF_W+CNT_W-1:0] && !TS_EN) begin bad++; $display("FAIL first_stable: got %h want %h", rif.rec_data, want); end
        total++; if (fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL first_level: got %0d want 1", fifo_level); end
        rif.rec_ready = 1'b1;
        tick();
        total++; if (rif.rec_valid !== 1'b0 || fifo_level !== '0) begin bad++; $display("FAIL first_drain: got valid=%b level=%0d want 0/0", rif.rec_valid, fifo_level); end
    endtask

    task automatic test_empty_push_pop();
        set_in(1'b1, 7, BUF_W'({$urandom, $urandom}), 1'b1);
        tick();
        total++; if (rif.rec_valid !== 1'b1 || fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL empty_pushpop: got valid=%b level=%0d want 1/1", rif.rec_valid, fifo_level); end
        total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL empty_pushpop_data: got %h want %h", rif.rec_data, q[0]); end
        set_in(1'b0, 0, '0, 1'b1);
        tick();
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL empty_pushpop_drain: got %0d want 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [DROP_W-1:0] drop0;
        drop0 = drop_count;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, $urandom_range(1, SLOTS), BUF_W'({$urandom, $urandom}), 1'b0);
            tick();
        end
        set_in(1'b0, 0, '0, 1'b0);
        total++; if (fifo_level !== LVL_W'(DEPTH)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, DEPTH); end
        total++; if (drop_count - drop0 !== DROP_W'(2)) begin bad++; $display("FAIL ovf_drop: got %0d want %0d", drop_count - drop0, 2); end
        total++; if (drop_count !== DROP_W'(m_drops)) begin bad++; $display("FAIL ovf_drop_model: got %0d want %0d", drop_count, m_drops); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rif.rec_valid !== 1'b1 || rif.rec_data !== q[0]) begin bad++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, rif.rec_valid, rif.rec_data, q[0]); end
            rif.rec_ready = 1'b1;
            tick();
        end
        total++; if (rif.rec_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", rif.rec_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [DROP_W-1:0] drop0;
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, $urandom_range(1, SLOTS), BUF_W'({$urandom, $urandom}), 1'b0);
            tick();
        end
        drop0 = drop_count;
        set_in(1'b1, $urandom_range(1, SLOTS), BUF_W'({$urandom, $urandom}), 1'b1);
        tick();
        set_in(1'b0, 0, '0, 1'b0);
        total++; if (fifo_level !== LVL_W'(DEPTH)) begin bad++; $display("FAIL fullpp_level: got %0d want %0d", fifo_level, DEPTH); end
        total++; if (drop_count !== drop0) begin bad++; $display("FAIL fullpp_drop: got %0d want %0d", drop_count, drop0); end
        total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL fullpp_head: got %h want %h", rif.rec_data, q[0]); end
        rif.rec_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL fullpp_drain[%0d]: got %h want %h", i, rif.rec_data, q[0]); end
            tick();
        end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL fullpp_empty: got %0d want 0", fifo_level); end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, SLOTS), BUF_W'({$urandom, $urandom}),
                   (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
            total++; if (rif.rec_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rif.rec_valid, q.size() != 0); end
            total++; if (fifo_level !== LVL_W'(q.size())) begin bad++; $display("FAIL rnd_level[%0d]: got %0d want %0d", i, fifo_level, q.size()); end
            total++; if (drop_count !== DROP_W'(m_drops)) begin bad++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", i, drop_count, m_drops); end
            if (q.size() != 0) begin
                total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rif.rec_data, q[0]); end
            end
        end
        set_in(1'b0, 0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL rnd_drain: got %0d want 0", fifo_level); end
    endtask

`ifdef OCI_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_in(c == 4 || c == 9, 2, BUF_W'({$urandom, $urandom}), 1'b0);
            tick();
        end
        set_in(1'b0, 0, '0, 1'b0);
        total++; if (rif.rec_data[REC_W-1 -: TS_W] !== 32'd4) begin bad++; $display("FAIL ts_first: got %0d want 4", rif.rec_data[REC_W-1 -: TS_W]); end
        total++; if (rif.rec_data !== q[0]) begin bad++; $display("FAIL ts_first_rec: got %h want %h", rif.rec_data, q[0]); end
        rif.rec_ready = 1'b1;
        tick();
        total++; if (rif.rec_data[REC_W-1 -: TS_W] !== 32'd9) begin bad++; $display("FAIL ts_second: got %0d want 9", rif.rec_data[REC_W-1 -: TS_W]); end
        tick();
    endtask
`endif

    task automatic test_end_sequence();
        int empty_at;
        int done_at;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, $urandom_range(1, SLOTS), BUF_W'({$urandom, $urandom}), 1'b0);
            tick();
        end
        set_in(1'b0, 0, '0, 1'b0);
        test_ending = 1'b1;
        tick();
        set_in(1'b1, 5, BUF_W'({$urandom, $urandom}), 1'b0);
        tick();
        set_in(1'b0, 0, '0, 1'b0);
        test_ending = 1'b0;
        tick();
        total++; if (fifo_level !== LVL_W'(2)) begin bad++; $display("FAIL end_nopush: got %0d want 2", fifo_level); end
        total++; if (drop_count !== '0) begin bad++; $display("FAIL end_nodrop: got %0d want 0", drop_count); end
        // A capture request here would be taken if the block had fallen back to capture.
        set_in(1'b1, 4, BUF_W'({$urandom, $urandom}), 1'b0);
        tick();
        set_in(1'b0, 0, '0, 1'b0);
        total++; if (fifo_level !== LVL_W'(2)) begin bad++; $display("FAIL end_sticky_flush: got %0d want 2", fifo_level); end
        test_has_ended = 1'b1;
        repeat (2) tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL end_done_early: got %b want 0", done); end
        rif.rec_ready = 1'b1;
        empty_at = -1;
        done_at  = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_level == '0 && empty_at < 0) empty_at = i;
            if (done === 1'b1 && done_at < 0) done_at = i;
            total++; if (done !== m_done) begin bad++; $display("FAIL end_done[%0d]: got %b want %b", i, done, m_done); end
        end
        total++; if (done_at - empty_at !== 2) begin bad++; $display("FAIL end_done_delay: got %0d want 2", done_at - empty_at); end
        test_has_ended = 1'b0;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL end_done_held: got %b want 1", done); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, $urandom_range(1, SLOTS), BUF_W'({$urandom, $urandom}), 1'b0);
            tick();
        end
        set_in(1'b0, 0, '0, 1'b1);
        tick();
        total++; if (fifo_level !== LVL_W'(5)) begin bad++; $display("FAIL mid_level: got %0d want 5", fifo_level); end
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (rif.rec_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", rif.rec_valid); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL mid_reset_level: got %0d want 0", fifo_level); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(1'b1, 9, BUF_W'({$urandom, $urandom}), 1'b0);
        tick();
        set_in(1'b0, 0, '0, 1'b0);
        total++; if (rif.rec_valid !== 1'b1 || rif.rec_data !== q[0]) begin bad++; $display("FAIL mid_recapture: got %b/%h want 1/%h", rif.rec_valid, rif.rec_data, q[0]); end
        total++; if (fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL mid_recapture_level: got %0d want 1", fifo_level); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_capture();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_random_traffic();
`ifdef OCI_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_end_sequence();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
